ar_tag_map: RTL and testbench
=============================

AR_TAG_MAP -- requirements
Module: ar_tag_map

Interface
REQ-001 Parameter ID_WIDTH, default 4, width of original and unique IDs.
REQ-002 Parameter NUM_UIDS, default 16, number of unique-ID slots; SHALL satisfy 2 <= NUM_UIDS <= 2**ID_WIDTH.
REQ-003 Port clk  input  1  clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port alloc_req  input  1  request a unique ID for the captured AR.
REQ-006 Port alloc_in_id  input  ID_WIDTH  original AR ID to record.
REQ-007 Port alloc_gnt  output  1  allocation granted this cycle.
REQ-008 Port unique_id  output  ID_WIDTH  granted slot index, valid when alloc_gnt=1.
REQ-009 Port tag_map_full  output  1  no free slot.
REQ-010 Port free_valid  input  1  release request from R path (last beat of a burst).
REQ-011 Port free_uid  input  ID_WIDTH  slot to release.
REQ-012 Port lookup_uid  input  ID_WIDTH  slot to translate back, for R responses.
REQ-013 Port lookup_orig_id  output  ID_WIDTH  original ID stored in slot lookup_uid.
REQ-014 Port lookup_hit  output  1  slot lookup_uid is currently allocated.
REQ-015 Port used_count  output  $clog2(NUM_UIDS+1)  number of allocated slots.
REQ-016 Port err_bad_free  output  1  sticky: a free targeted an unallocated or out-of-range slot.

Function
REQ-017 Per slot, state SHALL be a valid bit plus a stored original ID.
REQ-018 alloc_gnt SHALL be combinational: alloc_req & ~tag_map_full; no registered latency, so the requester latches the UID in the same cycle.
REQ-019 unique_id SHALL be the lowest-index slot whose valid bit is 0 at the start of the cycle; when no slot is free, its value is don't-care.
REQ-020 On a clock edge with alloc_gnt=1, the chosen slot SHALL set valid=1 and store alloc_in_id.
REQ-021 A clock edge with free_valid=1, free_uid < NUM_UIDS and that slot valid SHALL clear the slot's valid bit.
REQ-022 A free SHALL take effect on the next cycle only; no same-cycle bypass to the allocator or to tag_map_full.
REQ-023 Simultaneous alloc and free in one cycle SHALL both complete; used_count stays unchanged.
REQ-024 tag_map_full SHALL equal (used_count == NUM_UIDS), registered-state derived.
REQ-025 used_count SHALL update as +1 on grant only, -1 on legal free only, and stay unchanged on both or neither; it never wraps.
REQ-026 An illegal free (slot invalid or free_uid >= NUM_UIDS) SHALL change no slot or count and SHALL set err_bad_free until reset.
REQ-027 lookup_orig_id and lookup_hit SHALL be combinational reads of slot lookup_uid.
REQ-028 An out-of-range lookup_uid SHALL give lookup_hit=0 and lookup_orig_id=0.
REQ-029 alloc_req while full SHALL give alloc_gnt=0 and no state change; the request is held by the requester.

Reset
REQ-030 While rst=1, all valid bits, all stored IDs, used_count and err_bad_free SHALL be 0, tag_map_full SHALL be 0 and alloc_gnt SHALL follow alloc_req.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding allocations immediately.

Structure
REQ-032 Shared package SHALL hold ID_WIDTH/NUM_UIDS defaults, the count width and a slot-entry typedef {valid, orig_id}.
REQ-033 A sub-module ar_free_slot_finder SHALL implement the lowest-index free-slot priority encoder, with outputs found and index.
REQ-034 The block SHALL connect directly to the AR ordering stage's alloc_req/alloc_in_id/alloc_gnt/unique_id/tag_map_full.

Verification
REQ-035 After reset, alloc_req=1 with alloc_in_id=5 -> same-cycle alloc_gnt=1 and unique_id=0; next cycle used_count=1 and lookup_uid=0 gives orig_id 5 with hit=1.
REQ-036 Sixteen back-to-back grants -> UIDs 0..15 in order, then tag_map_full=1; a 17th request gives alloc_gnt=0.
REQ-037 While full, free_uid=7 -> next cycle full=0; the next grant returns unique_id=7.
REQ-038 With slots 0-3 used, alloc and free_uid=2 in the same cycle -> grant uid=4 and used_count stays 4; on the next request, uid=2.
REQ-039 free_uid=9 while slot 9 is invalid -> err_bad_free=1 and used_count unchanged; it stays 1 until rst.
REQ-040 rst pulsed with 10 slots used -> used_count=0, full=0, every lookup_hit=0 and the first grant is uid=0.

Source files
------------

// File: rtl/ar_tag_map_pkg.sv
// ar_tag_map_pkg: shared defaults, count-width helper and slot entry type for the AR tag map.
package ar_tag_map_pkg;

    localparam int ID_WIDTH_DEF = 4;
    localparam int NUM_UIDS_DEF = 16;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [ID_WIDTH_DEF-1:0] orig_id;
    } slot_t;

endpackage

// File: rtl/ar_free_slot_finder.sv
// ar_free_slot_finder: lowest-index free-slot priority encoder.
module ar_free_slot_finder #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  used_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!used_i[i]) begin
                found_o = 1'b1;
                index_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ar_tag_map.sv
// ar_tag_map: maps AR IDs onto unique slot IDs and translates them back for R responses.
module ar_tag_map
    import ar_tag_map_pkg::*;
#(
    parameter  int ID_WIDTH = ID_WIDTH_DEF,
    parameter  int NUM_UIDS = NUM_UIDS_DEF,
    localparam int CW       = cnt_width(NUM_UIDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    input  logic [ID_WIDTH-1:0] alloc_in_id,
    output logic                alloc_gnt,
    output logic [ID_WIDTH-1:0] unique_id,
    output logic                tag_map_full,
    input  logic                free_valid,
    input  logic [ID_WIDTH-1:0] free_uid,
    input  logic [ID_WIDTH-1:0] lookup_uid,
    output logic [ID_WIDTH-1:0] lookup_orig_id,
    output logic                lookup_hit,
    output logic [CW-1:0]       used_count,
    output logic                err_bad_free
);

    if (ID_WIDTH != ID_WIDTH_DEF || NUM_UIDS < 2 || NUM_UIDS > 2**ID_WIDTH) begin : g_param_check
        $error("ar_tag_map: unsupported ID_WIDTH/NUM_UIDS combination");
    end

    slot_t             slot_q [NUM_UIDS];
    slot_t             slot_d [NUM_UIDS];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [NUM_UIDS-1:0] used_vec;
    logic              found;
    logic              free_ok;

    ar_free_slot_finder #(.N(NUM_UIDS), .IW(ID_WIDTH)) u_finder (
        .used_i (used_vec),
        .found_o(found),
        .index_o(unique_id)
    );

    assign tag_map_full = cnt_q == CW'(NUM_UIDS);
    assign alloc_gnt    = alloc_req & ~tag_map_full & found;
    assign used_count   = cnt_q;
    assign err_bad_free = err_q;

    // Out-of-range slot numbers simply never match, so they read as unallocated.
    always_comb begin
        used_vec       = '0;
        free_ok        = 1'b0;
        lookup_hit     = 1'b0;
        lookup_orig_id = '0;
        for (int i = 0; i < NUM_UIDS; i++) begin
            used_vec[i] = slot_q[i].valid;
            if (free_uid == ID_WIDTH'(i)) free_ok = free_valid & slot_q[i].valid;
            if (lookup_uid == ID_WIDTH'(i)) begin
                lookup_hit     = slot_q[i].valid;
                lookup_orig_id = slot_q[i].orig_id;
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < NUM_UIDS; i++) begin
            if (alloc_gnt && unique_id == ID_WIDTH'(i)) slot_d[i] = '{valid: 1'b1, orig_id: alloc_in_id};
            else if (free_ok && free_uid == ID_WIDTH'(i)) slot_d[i].valid = 1'b0;
        end
        cnt_d = (alloc_gnt && !free_ok) ? cnt_q + 1'b1 : (free_ok && !alloc_gnt) ? cnt_q - 1'b1 : cnt_q;
        err_d = err_q | (free_valid & ~free_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_UIDS; i++) slot_q[i] <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_ar_tag_map.sv
// tb_ar_tag_map: directed scenario checks for the AR tag map.
module tb_ar_tag_map;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_req = 1'b0;
    logic [3:0] alloc_in_id = '0;
    logic       alloc_gnt;
    logic [3:0] unique_id;
    logic       tag_map_full;
    logic       free_valid = 1'b0;
    logic [3:0] free_uid = '0;
    logic [3:0] lookup_uid = '0;
    logic [3:0] lookup_orig_id;
    logic       lookup_hit;
    logic [4:0] used_count;
    logic       err_bad_free;

    int n_chk  = 0;
    int n_pass = 0;

    ar_tag_map dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (alloc_req),
        .alloc_in_id   (alloc_in_id),
        .alloc_gnt     (alloc_gnt),
        .unique_id     (unique_id),
        .tag_map_full  (tag_map_full),
        .free_valid    (free_valid),
        .free_uid      (free_uid),
        .lookup_uid    (lookup_uid),
        .lookup_orig_id(lookup_orig_id),
        .lookup_hit    (lookup_hit),
        .used_count    (used_count),
        .err_bad_free  (err_bad_free)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_req   = 1'b1;
            alloc_in_id = 4'(i + 1);
            step();
        end
        alloc_req = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alloc_req = 1'b1;
        lookup_uid = 4'd0;
        step();
        n_chk++;
        if (alloc_gnt !== 1'b1) $display("FAIL reset_gnt_follows_req got=%b exp=1", alloc_gnt); else n_pass++;
        n_chk++;
        if ({tag_map_full, used_count, err_bad_free, lookup_hit} !== 8'b0)
            $display("FAIL reset_state full=%b used=%0d err=%b hit=%b exp all 0", tag_map_full, used_count, err_bad_free, lookup_hit);
        else n_pass++;
        alloc_req = 1'b0;
        #1;
        n_chk++;
        if (alloc_gnt !== 1'b0) $display("FAIL reset_gnt_low got=%b exp=0", alloc_gnt); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_first_alloc();
        do_reset();
        alloc_req = 1'b1;
        alloc_in_id = 4'd5;
        #1;
        n_chk++;
        if (alloc_gnt !== 1'b1 || unique_id !== 4'd0)
            $display("FAIL first_grant gnt=%b uid=%0d exp gnt=1 uid=0", alloc_gnt, unique_id);
        else n_pass++;
        step();
        alloc_req = 1'b0;
        lookup_uid = 4'd0;
        #1;
        n_chk++;
        if (used_count !== 5'd1 || lookup_orig_id !== 4'd5 || lookup_hit !== 1'b1)
            $display("FAIL first_lookup used=%0d orig=%0d hit=%b exp 1/5/1", used_count, lookup_orig_id, lookup_hit);
        else n_pass++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_req = 1'b1;
            alloc_in_id = 4'(15 - i);
            #1;
            n_chk++;
            if (alloc_gnt !== 1'b1 || unique_id !== 4'(i))
                $display("FAIL fill_grant_%0d gnt=%b uid=%0d exp gnt=1 uid=%0d", i, alloc_gnt, unique_id, i);
            else n_pass++;
            step();
        end
        n_chk++;
        if (tag_map_full !== 1'b1 || used_count !== 5'd16)
            $display("FAIL fill_full full=%b used=%0d exp 1/16", tag_map_full, used_count);
        else n_pass++;
        n_chk++;
        if (alloc_gnt !== 1'b0) $display("FAIL fill_17th_gnt got=%b exp=0", alloc_gnt); else n_pass++;
        step();
        alloc_req = 1'b0;
        lookup_uid = 4'd3;
        #1;
        n_chk++;
        if (used_count !== 5'd16 || lookup_orig_id !== 4'd12 || lookup_hit !== 1'b1)
            $display("FAIL fill_hold used=%0d orig=%0d hit=%b exp 16/12/1", used_count, lookup_orig_id, lookup_hit);
        else n_pass++;
    endtask

    task automatic test_free_full();
        free_valid = 1'b1;
        free_uid = 4'd7;
        alloc_req = 1'b1;
        alloc_in_id = 4'd11;
        #1;
        n_chk++;
        if (tag_map_full !== 1'b1 || alloc_gnt !== 1'b0)
            $display("FAIL free_no_bypass full=%b gnt=%b exp 1/0", tag_map_full, alloc_gnt);
        else n_pass++;
        step();
        free_valid = 1'b0;
        lookup_uid = 4'd7;
        #1;
        n_chk++;
        if (tag_map_full !== 1'b0 || used_count !== 5'd15 || lookup_hit !== 1'b0)
            $display("FAIL free_full_after full=%b used=%0d hit=%b exp 0/15/0", tag_map_full, used_count, lookup_hit);
        else n_pass++;
        n_chk++;
        if (alloc_gnt !== 1'b1 || unique_id !== 4'd7)
            $display("FAIL free_regrant gnt=%b uid=%0d exp 1/7", alloc_gnt, unique_id);
        else n_pass++;
        step();
        alloc_req = 1'b0;
        #1;
        n_chk++;
        if (tag_map_full !== 1'b1 || lookup_orig_id !== 4'd11 || lookup_hit !== 1'b1)
            $display("FAIL free_refill full=%b orig=%0d hit=%b exp 1/11/1", tag_map_full, lookup_orig_id, lookup_hit);
        else n_pass++;
    endtask

    task automatic test_alloc_free_same_cycle();
        do_reset();
        alloc_n(4);
        alloc_req = 1'b1;
        alloc_in_id = 4'd9;
        free_valid = 1'b1;
        free_uid = 4'd2;
        #1;
        n_chk++;
        if (alloc_gnt !== 1'b1 || unique_id !== 4'd4)
            $display("FAIL both_grant gnt=%b uid=%0d exp 1/4", alloc_gnt, unique_id);
        else n_pass++;
        step();
        alloc_req = 1'b0;
        free_valid = 1'b0;
        lookup_uid = 4'd4;
        #1;
        n_chk++;
        if (used_count !== 5'd4 || lookup_orig_id !== 4'd9 || lookup_hit !== 1'b1)
            $display("FAIL both_count used=%0d orig=%0d hit=%b exp 4/9/1", used_count, lookup_orig_id, lookup_hit);
        else n_pass++;
        lookup_uid = 4'd2;
        alloc_req = 1'b1;
        alloc_in_id = 4'd6;
        #1;
        n_chk++;
        if (lookup_hit !== 1'b0 || unique_id !== 4'd2 || alloc_gnt !== 1'b1)
            $display("FAIL both_next hit=%b uid=%0d gnt=%b exp 0/2/1", lookup_hit, unique_id, alloc_gnt);
        else n_pass++;
        step();
        alloc_req = 1'b0;
        #1;
        n_chk++;
        if (used_count !== 5'd5 || err_bad_free !== 1'b0)
            $display("FAIL both_after used=%0d err=%b exp 5/0", used_count, err_bad_free);
        else n_pass++;
    endtask

    task automatic test_bad_free();
        free_valid = 1'b1;
        free_uid = 4'd9;
        step();
        free_valid = 1'b0;
        #1;
        n_chk++;
        if (err_bad_free !== 1'b1 || used_count !== 5'd5)
            $display("FAIL bad_free err=%b used=%0d exp 1/5", err_bad_free, used_count);
        else n_pass++;
        free_valid = 1'b1;
        free_uid = 4'd0;
        step();
        free_valid = 1'b0;
        step();
        step();
        lookup_uid = 4'd0;
        #1;
        n_chk++;
        if (err_bad_free !== 1'b1 || used_count !== 5'd4 || lookup_hit !== 1'b0)
            $display("FAIL bad_free_sticky err=%b used=%0d hit=%b exp 1/4/0", err_bad_free, used_count, lookup_hit);
        else n_pass++;
        free_valid = 1'b1;
        free_uid = 4'd0;
        step();
        free_valid = 1'b0;
        #1;
        n_chk++;
        if (used_count !== 5'd4) $display("FAIL double_free_count got=%0d exp=4", used_count); else n_pass++;
        do_reset();
        n_chk++;
        if (err_bad_free !== 1'b0) $display("FAIL bad_free_clear got=%b exp=0", err_bad_free); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hits;
        do_reset();
        alloc_n(10);
        n_chk++;
        if (used_count !== 5'd10) $display("FAIL mid_pre_used got=%0d exp=10", used_count); else n_pass++;
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (used_count !== 5'd0 || tag_map_full !== 1'b0)
            $display("FAIL mid_async used=%0d full=%b exp 0/0", used_count, tag_map_full);
        else n_pass++;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            lookup_uid = 4'(i);
            #0.1;
            if (lookup_hit !== 1'b0 || lookup_orig_id !== 4'd0) hits++;
        end
        n_chk++;
        if (hits !== 0) $display("FAIL mid_lookups live_or_nonzero=%0d exp=0", hits); else n_pass++;
        step();
        rst = 1'b0;
        alloc_req = 1'b1;
        alloc_in_id = 4'd3;
        #1;
        n_chk++;
        if (alloc_gnt !== 1'b1 || unique_id !== 4'd0)
            $display("FAIL mid_first_grant gnt=%b uid=%0d exp 1/0", alloc_gnt, unique_id);
        else n_pass++;
        step();
        alloc_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_alloc();
        test_fill();
        test_free_full();
        test_alloc_free_same_cycle();
        test_bad_free();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
